// File: rtl/pad_trig_pkg.sv
// Shared definitions for the pad coincidence trigger.
//   - Default layer count, pad width and pad index width.
//   - Coincidence-map width (one bit per possible layer-hit vector).
//   - Trigger FSM state encoding.
package pad_trig_pkg;

    localparam int NUM_LAYERS_DEF = 4;
    localparam int PAD_WIDTH_DEF  = 104;
    localparam int SEL_WIDTH_DEF  = 7;
    localparam int MAP_WIDTH_DEF  = 2 ** NUM_LAYERS_DEF;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_HOLDOFF = 1'b1
    } trig_state_e;

endpackage

// File: rtl/pad_layer_stretch.sv
// One pad layer: selects a single pad bit by runtime index (stage 1) and
// stretches a hit over a window of window_len extra cycles (stage 2).
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   i_pad_data     this layer's pad bits
//   i_sel          {enable, index} for this layer
//   i_s1_valid     stage-1 valid (shared across layers, held by the top)
//   i_window_len   window length, sampled only when a hit loads the counter
//   o_stretch      combinational stretched hit, registered by the top
module pad_layer_stretch
    import pad_trig_pkg::*;
#(
    parameter int PAD_WIDTH = PAD_WIDTH_DEF,
    parameter int SEL_WIDTH = SEL_WIDTH_DEF,
    parameter int WIN_WIDTH = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [PAD_WIDTH-1:0] i_pad_data,
    input  logic [SEL_WIDTH:0]   i_sel,
    input  logic                 i_s1_valid,
    input  logic [WIN_WIDTH-1:0] i_window_len,
    output logic                 o_stretch
);

    logic                 w_en;
    logic [SEL_WIDTH-1:0] w_idx;
    logic                 w_bit;
    logic                 w_hit;
    logic                 r_s1_bit;
    logic [WIN_WIDTH-1:0] r_cnt;

    assign w_en  = i_sel[SEL_WIDTH];
    assign w_idx = i_sel[SEL_WIDTH-1:0];
    // Indices beyond the last pad read as no hit rather than wrapping.
    assign w_bit = (int'(w_idx) < PAD_WIDTH) ? i_pad_data[w_idx] : 1'b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_s1_bit <= 1'b0;
        else        r_s1_bit <= w_en & w_bit;
    end

    assign w_hit = i_s1_valid & r_s1_bit;

    // A new hit reloads the window; it never extends an existing one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              r_cnt <= '0;
        else if (w_hit)          r_cnt <= i_window_len;
        else if (r_cnt != '0)    r_cnt <= r_cnt - WIN_WIDTH'(1);
    end

    assign o_stretch = w_hit | (r_cnt != '0);

endmodule

// File: rtl/pad_coincidence_trigger.sv
// Pad coincidence trigger: per-layer pad select and window stretch, map
// lookup of the layer-hit vector, qualified trigger with hold-off, and a
// saturating trigger counter.
// Interface: data_valid_in qualifies pad_data/pad_sel for one cycle; there
// is no back-pressure. pad_hited_clear is a single-cycle trigger strobe.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   data_valid_in     pad_data / pad_sel valid this cycle
//   pad_data          layer i at [i*PAD_WIDTH +: PAD_WIDTH]
//   pad_sel           per layer {enable, index}
//   pad_matched_map   bit k set: layer vector k triggers
//   window_len        extra cycles a layer hit stays visible
//   holdoff_len       cycles suppressed after a trigger
//   cnt_clear         synchronous clear of trig_count
//   layer_hit         registered stretched layer vector
//   pad_hited         registered raw coincidence result
//   pad_hited_clear   qualified trigger pulse
//   trig_count        saturating trigger count
//   o_dbg_state       trigger FSM state
module pad_coincidence_trigger
    import pad_trig_pkg::*;
#(
    parameter int NUM_LAYERS = NUM_LAYERS_DEF,
    parameter int PAD_WIDTH  = PAD_WIDTH_DEF,
    parameter int SEL_WIDTH  = SEL_WIDTH_DEF,
    parameter int WIN_WIDTH  = 3,
    parameter int HOLD_WIDTH = 4,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               data_valid_in,
    input  logic [NUM_LAYERS*PAD_WIDTH-1:0]    pad_data,
    input  logic [NUM_LAYERS*(SEL_WIDTH+1)-1:0] pad_sel,
    input  logic [2**NUM_LAYERS-1:0]           pad_matched_map,
    input  logic [WIN_WIDTH-1:0]               window_len,
    input  logic [HOLD_WIDTH-1:0]              holdoff_len,
    input  logic                               cnt_clear,
    output logic [NUM_LAYERS-1:0]              layer_hit,
    output logic                               pad_hited,
    output logic                               pad_hited_clear,
    output logic [CNT_WIDTH-1:0]               trig_count,
    output logic                               o_dbg_state
);

    logic                  r_s1_valid;
    logic                  r_s2_valid;
    logic [NUM_LAYERS-1:0] w_stretch;
    logic [NUM_LAYERS-1:0] r_layer_hit;
    logic                  r_pad_hited;
    trig_state_e           r_state, w_state_nxt;
    logic [HOLD_WIDTH-1:0] r_hold_cnt, w_hold_nxt;
    logic                  w_fire;
    logic                  r_clear;
    logic [CNT_WIDTH-1:0]  r_trig_count;

    for (genvar gi = 0; gi < NUM_LAYERS; gi++) begin : g_layer
        pad_layer_stretch #(
            .PAD_WIDTH (PAD_WIDTH),
            .SEL_WIDTH (SEL_WIDTH),
            .WIN_WIDTH (WIN_WIDTH)
        ) u_stretch (
            .clk          (clk),
            .rst_n        (rst_n),
            .i_pad_data   (pad_data[gi*PAD_WIDTH +: PAD_WIDTH]),
            .i_sel        (pad_sel[gi*(SEL_WIDTH+1) +: SEL_WIDTH+1]),
            .i_s1_valid   (r_s1_valid),
            .i_window_len (window_len),
            .o_stretch    (w_stretch[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_layer_hit <= '0;
            r_pad_hited <= 1'b0;
        end else begin
            r_s1_valid  <= data_valid_in;
            r_s2_valid  <= r_s1_valid;
            r_layer_hit <= w_stretch;
            r_pad_hited <= pad_matched_map[w_stretch];
        end
    end

    // Hold counter counts holdoff_len..1; leaving at 1 gives exactly
    // holdoff_len suppressed cycles after the trigger cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold_cnt;
        w_fire      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_s2_valid && r_pad_hited) begin
                    w_fire = 1'b1;
                    if (holdoff_len != '0) begin
                        w_hold_nxt  = holdoff_len;
                        w_state_nxt = ST_HOLDOFF;
                    end
                end
            end
            ST_HOLDOFF: begin
                if (r_hold_cnt <= HOLD_WIDTH'(1)) begin
                    w_hold_nxt  = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_hold_nxt = r_hold_cnt - HOLD_WIDTH'(1);
                end
            end
            default: begin
                w_hold_nxt  = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_hold_cnt <= '0;
            r_clear    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_hold_cnt <= w_hold_nxt;
            r_clear    <= w_fire;
        end
    end

    // Clear wins over a coincident increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                        r_trig_count <= '0;
        else if (cnt_clear)                r_trig_count <= '0;
        else if (w_fire && !(&r_trig_count)) r_trig_count <= r_trig_count + CNT_WIDTH'(1);
    end

    assign layer_hit       = r_layer_hit;
    assign pad_hited       = r_pad_hited;
    assign pad_hited_clear = r_clear;
    assign trig_count      = r_trig_count;
    assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_pad_coincidence_trigger.sv
module tb_pad_coincidence_trigger;

    localparam int NL  = 4;
    localparam int PW  = 104;
    localparam int SW  = 7;
    localparam int WW  = 3;
    localparam int HW  = 4;
    localparam int CW  = 4;
    localparam int W   = 32;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  data_valid_in = 1'b0;
    logic [NL*PW-1:0]      pad_data = '0;
    logic [NL*(SW+1)-1:0]  pad_sel = '0;
    logic [2**NL-1:0]      pad_matched_map = '0;
    logic [WW-1:0]         window_len = '0;
    logic [HW-1:0]         holdoff_len = '0;
    logic                  cnt_clear = 1'b0;
    logic [NL-1:0]         layer_hit;
    logic                  pad_hited;
    logic                  pad_hited_clear;
    logic [CW-1:0]         trig_count;
    logic                  o_dbg_state;

    pad_coincidence_trigger #(
        .NUM_LAYERS (NL), .PAD_WIDTH (PW), .SEL_WIDTH (SW),
        .WIN_WIDTH (WW), .HOLD_WIDTH (HW), .CNT_WIDTH (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .data_valid_in   (data_valid_in),
        .pad_data        (pad_data),
        .pad_sel         (pad_sel),
        .pad_matched_map (pad_matched_map),
        .window_len      (window_len),
        .holdoff_len     (holdoff_len),
        .cnt_clear       (cnt_clear),
        .layer_hit       (layer_hit),
        .pad_hited       (pad_hited),
        .pad_hited_clear (pad_hited_clear),
        .trig_count      (trig_count),
        .o_dbg_state     (o_dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    // Expected pulse: {edge number [31:16], trig_count after it [15:0]}
    logic [W-1:0] exp_q[$];

    logic         sel_en  [NL];
    logic [SW-1:0] sel_idx [NL];
    logic         fill_l1 = 1'b0;

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && pad_hited_clear) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pulse: pulse at edge %0d count %0d, none expected", cyc, trig_count);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (e[31:16] != cyc[15:0] || e[15:0] != 16'(trig_count)) begin
                    n_err++;
                    $display("FAIL pulse: got edge %0d count %0d, expected edge %0d count %0d",
                             cyc, trig_count, e[31:16], e[15:0]);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input int unsigned edge_n, input int unsigned cnt);
        exp_q.push_back({edge_n[15:0], cnt[15:0]});
    endtask

    // Drive one cycle: layers in mask get pad bit 5 set; returns after the
    // capturing edge (+1 time unit).
    task automatic step(input logic v, input logic [NL-1:0] mask);
        logic [NL*PW-1:0] pd;
        logic [NL*(SW+1)-1:0] ps;
        pd = '0;
        for (int i = 0; i < NL; i++) begin
            if (mask[i]) pd[i*PW + 5] = 1'b1;
            ps[i*(SW+1) +: SW+1] = {sel_en[i], sel_idx[i]};
        end
        if (fill_l1) pd[PW +: PW] = '1;
        data_valid_in = v;
        pad_data      = pd;
        pad_sel       = ps;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0);
    endtask

    task automatic drain(input string name);
        idle(12);
        check(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic clear_count();
        cnt_clear = 1'b1;
        idle(1);
        cnt_clear = 1'b0;
        check("count_cleared", 32'(trig_count), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        int unsigned e;
        for (int i = 0; i < NL; i++) begin
            sel_en[i]  = 1'b1;
            sel_idx[i] = 7'd5;
        end
        pad_matched_map = 16'h8000;
        repeat (3) @(posedge clk);
        #1;
        check("reset_layer_hit", 32'(layer_hit), 0);
        check("reset_pad_hited", 32'(pad_hited), 0);
        check("reset_clear",     32'(pad_hited_clear), 0);
        check("reset_count",     32'(trig_count), 0);
        check("reset_state",     32'(o_dbg_state), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: single all-layer hit, no window, no hold-off
        window_len = 0; holdoff_len = 0;
        e = cyc;
        push_exp(e + 3, 1);
        step(1'b1, 4'hF);
        step(1'b0, '0);
        check("t1_layer_hit", 32'(layer_hit), 32'hF);
        check("t1_pad_hited", 32'(pad_hited), 1);
        step(1'b0, '0);
        check("t1_count", 32'(trig_count), 1);
        step(1'b0, '0);
        check("t1_one_cycle", 32'(pad_hited_clear), 0);
        drain("t1_drain");
        clear_count();

        // 2: window_len=2 overlap at cycle 2 triggers, at cycle 3 does not
        window_len = 2;
        idle(2);
        e = cyc;
        push_exp(e + 5, 1);
        step(1'b1, 4'b0011);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b1100);
        drain("t2a_drain");
        check("t2a_count", 32'(trig_count), 1);
        step(1'b1, 4'b0011);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b0000);
        step(1'b1, 4'b1100);
        drain("t2b_drain");
        check("t2b_count", 32'(trig_count), 1);
        clear_count();

        // 3: hold-off 3 with six consecutive all-layer hits
        window_len = 0; holdoff_len = 3;
        idle(2);
        e = cyc;
        push_exp(e + 3, 1);
        push_exp(e + 7, 2);
        for (int i = 0; i < 6; i++) step(1'b1, 4'hF);
        drain("t3_drain");
        check("t3_count", 32'(trig_count), 2);
        clear_count();

        // 4: layer 1 disabled / out-of-range index
        holdoff_len = 0;
        sel_en[1] = 1'b0;
        step(1'b1, 4'hF);
        step(1'b0, '0);
        check("t4_dis_layer_hit", 32'(layer_hit), 32'hD);
        check("t4_dis_pad_hited", 32'(pad_hited), 0);
        drain("t4_dis_drain");
        sel_en[1] = 1'b1; sel_idx[1] = 7'd110; fill_l1 = 1'b1;
        step(1'b1, 4'hF);
        step(1'b0, '0);
        check("t4_oor_layer_hit", 32'(layer_hit), 32'hD);
        drain("t4_oor_drain");
        pad_matched_map = 16'h2000;
        e = cyc;
        push_exp(e + 3, 1);
        step(1'b1, 4'hF);
        drain("t4_map13_drain");
        check("t4_map13_count", 32'(trig_count), 1);
        sel_idx[1] = 7'd5; fill_l1 = 1'b0;
        pad_matched_map = 16'h8000;
        clear_count();

        // 5: saturation at 15, then clear coincident with a trigger
        for (int k = 1; k <= 20; k++) begin
            e = cyc;
            push_exp(e + 3, (k > 15) ? 15 : k);
            step(1'b1, 4'hF);
            step(1'b0, '0);
        end
        drain("t5_sat_drain");
        check("t5_sat_count", 32'(trig_count), 15);
        e = cyc;
        push_exp(e + 3, 0);
        step(1'b1, 4'hF);
        step(1'b0, '0);
        cnt_clear = 1'b1;
        step(1'b0, '0);
        cnt_clear = 1'b0;
        drain("t5_clr_drain");
        check("t5_clr_count", 32'(trig_count), 0);

        // 6: asynchronous reset during hold-off with live windows
        window_len = 3; holdoff_len = 5;
        e = cyc;
        push_exp(e + 3, 1);
        step(1'b1, 4'hF);
        idle(3);
        check("t6_in_holdoff", 32'(o_dbg_state), 1);
        check("t6_window_live", 32'(layer_hit), 32'hF);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_rst_layer_hit", 32'(layer_hit), 0);
        check("t6_rst_pad_hited", 32'(pad_hited), 0);
        check("t6_rst_clear",     32'(pad_hited_clear), 0);
        check("t6_rst_count",     32'(trig_count), 0);
        check("t6_rst_state",     32'(o_dbg_state), 0);
        check("t6_q_empty",       exp_q.size(), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(2);
        check("t6_post_layer_hit", 32'(layer_hit), 0);
        e = cyc;
        push_exp(e + 3, 1);
        step(1'b1, 4'hF);
        drain("t6_post_drain");
        check("t6_post_count", 32'(trig_count), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
